ddr_rx_sequencer: RTL and testbench
===================================

// Module: ddr_rx_sequencer
// PURPOSE
//  Controller that sequences the HDR-DDR receive datapath (RX) in controller-read transfers.
//  Drives RX enable/mode through preamble -> data word(s) -> parity -> CRC word, and consumes RX done/pre/error flags.
//  Counts received words and reports completion or error to the DDR CCC engine.
//  Sits between the DDR CCC FSM (start/abort/status) and RX; one instance per controller.
// PARAMETERS
//  MAX_WORDS  16  max data words per transfer; the word after MAX_WORDS must be a CRC word, else error
//  WCNT_W     5   width of o_word_count; must satisfy 2**WCNT_W > MAX_WORDS
// PORTS
//  i_sys_clk              in   1  system clock; single clock domain
//  i_sys_rst              in   1  asynchronous, active-low reset
//  i_sclgen_scl_pos_edge  in   1  one-cycle strobe on SCL rising edge
//  i_sclgen_scl_neg_edge  in   1  one-cycle strobe on SCL falling edge
//  i_ccc_start            in   1  pulse: begin a read transfer (ignored unless IDLE)
//  i_ccc_abort            in   1  level: abandon the transfer, return to IDLE
//  i_rx_mode_done         in   1  RX current-mode done
//  i_rx_pre               in   1  RX sampled preamble bit
//  i_rx_error             in   1  RX token/parity/CRC mismatch
//  i_rx_error_done        in   1  RX error-recovery complete
//  o_rx_en                out  1  RX enable
//  o_rx_mode              out  4  RX mode select (package encodings)
//  o_byte_valid           out  1  pulse: RX data byte ready (one per deserialized byte)
//  o_word_count           out  WCNT_W  data words accepted in this transfer
//  o_busy                 out  1  high in every state except IDLE
//  o_done                 out  1  one-cycle pulse: transfer ended with a good CRC
//  o_error                out  1  one-cycle pulse on entry to ERR
// BEHAVIOUR
//  Reset values: o_rx_en=0, o_rx_mode=RX_PREAMBLE, o_byte_valid=0, o_word_count=0, o_busy=0, o_done=0, o_error=0.
//  All outputs are registered. A state change takes effect on o_rx_mode one cycle after the triggering input.
//  States: IDLE, PRE0, PRE1, BYTE0, BYTE1, PAR, TOKEN, CRC, ERR, FIN.
//  IDLE: o_rx_en=0. i_ccc_start -> PRE0; clear o_word_count.
//  PRE0/PRE1 (mode RX_PREAMBLE):
//   - Any SCL edge strobe sets an internal 'armed' flag.
//   - First cycle with armed && i_rx_mode_done samples i_rx_pre and clears armed.
//   - Decoded {pre0,pre1}: 11 -> BYTE0 (data word); 01 -> TOKEN (CRC word); 00/10 -> ERR.
//   - A data word when o_word_count==MAX_WORDS -> ERR.
//  BYTE0/BYTE1 (mode RX_DESER_BYTE): i_rx_mode_done pulses o_byte_valid, then advances to BYTE1, then PAR.
//  PAR (mode RX_CHK_PAR): on i_rx_mode_done, increment o_word_count, then go to PRE0.
//  TOKEN (mode RX_CHK_TOKEN): done -> CRC.
//  CRC (mode RX_CHK_CRC): done -> FIN.
//  Error sampling: i_rx_error high in PAR/TOKEN/CRC, or in the first cycle of the state after them, -> ERR.
//   It overrides any advance in the same cycle.
//  ERR (mode RX_ERROR): o_error pulses on entry. Waits for i_rx_error_done -> IDLE; o_word_count holds its value.
//  FIN: o_done pulse for one cycle, o_rx_en=0, -> IDLE.
//  o_rx_en=1 in PRE0..CRC and ERR.
//  i_ccc_abort, in any state: next state IDLE, o_rx_en=0, no o_done/o_error pulse. Abort has priority over all other inputs.
//  i_ccc_start outside IDLE is ignored.
//  o_word_count saturates at MAX_WORDS; never wraps.
//  Reset asserted mid-transfer returns all state to reset values asynchronously.
// STRUCTURE
//  Shared package ddr_rx_pkg holds:
//   - RX mode localparams: RX_PREAMBLE=4'b0000, RX_DESER_BYTE=4'b0011, RX_CHK_TOKEN=4'b0101,
//     RX_CHK_PAR=4'b0110, RX_CHK_CRC=4'b0111, RX_ERROR=4'b1111.
//   - Preamble codes: PRE_DATA=2'b11, PRE_CRC=2'b01.
//  Single FSM module; no sub-modules. Word counter and armed flag live inline.
// TESTING
//  - 1 word: start, pre 11, 2 bytes, parity ok, pre 01, token/CRC ok
//    -> 2 o_byte_valid pulses, o_word_count=1, o_done once.
//  - 16 words then CRC word -> o_word_count=16, o_done.
//    A 17th data preamble (11) -> o_error, state ERR, then i_rx_error_done -> IDLE.
//  - i_rx_error in the cycle after PAR done -> ERR, o_error pulse, no o_byte_valid for the next word.
//  - Preamble 10 -> ERR. Preamble done without a preceding SCL edge -> ignored, stays in PRE0.
//  - i_ccc_abort during BYTE1 -> IDLE next cycle, o_rx_en=0, no done/error pulse.
//    A new i_ccc_start then restarts with o_word_count=0.
//  - i_sys_rst low mid-CRC -> all outputs at reset values; i_ccc_start during BUSY is ignored.

Source files
------------

// File: rtl/ddr_rx_pkg.sv
// Shared definitions for the HDR-DDR receive sequencer: RX mode encodings,
// preamble codes, FSM state type and state-to-output helpers.
package ddr_rx_pkg;

  localparam logic [3:0] RX_PREAMBLE   = 4'b0000;
  localparam logic [3:0] RX_DESER_BYTE = 4'b0011;
  localparam logic [3:0] RX_CHK_TOKEN  = 4'b0101;
  localparam logic [3:0] RX_CHK_PAR    = 4'b0110;
  localparam logic [3:0] RX_CHK_CRC    = 4'b0111;
  localparam logic [3:0] RX_ERROR      = 4'b1111;

  localparam logic [1:0] PRE_DATA = 2'b11;
  localparam logic [1:0] PRE_CRC  = 2'b01;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE0,
    ST_PRE1,
    ST_BYTE0,
    ST_BYTE1,
    ST_PAR,
    ST_TOKEN,
    ST_CRC,
    ST_ERR,
    ST_FIN
  } rx_state_t;

  // RX mode presented while the FSM sits in a given state.
  function automatic logic [3:0] state_to_mode(input rx_state_t s);
    logic [3:0] m;
    m = RX_PREAMBLE;
    case (s)
      ST_BYTE0, ST_BYTE1: m = RX_DESER_BYTE;
      ST_PAR:             m = RX_CHK_PAR;
      ST_TOKEN:           m = RX_CHK_TOKEN;
      ST_CRC:             m = RX_CHK_CRC;
      ST_ERR:             m = RX_ERROR;
      default:            m = RX_PREAMBLE;
    endcase
    return m;
  endfunction

  // RX stays enabled through the whole receive path and while error recovery runs.
  function automatic logic state_rx_en(input rx_state_t s);
    logic en;
    en = 1'b0;
    case (s)
      ST_PRE0, ST_PRE1, ST_BYTE0, ST_BYTE1,
      ST_PAR, ST_TOKEN, ST_CRC, ST_ERR: en = 1'b1;
      default:                          en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/ddr_rx_sequencer.sv
// HDR-DDR receive sequencer for controller-read transfers.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a start request, RX disabled
// PRE0  | collecting first preamble bit
// PRE1  | collecting second preamble bit, decode data word / CRC word
// BYTE0 | deserializing first byte of a data word
// BYTE1 | deserializing second byte of a data word
// PAR   | parity check of the data word, counts the word on success
// TOKEN | CRC word token check
// CRC   | CRC value check
// ERR   | error reported, waiting for RX error recovery to finish
// FIN   | last chance for a late RX error, then good completion
module ddr_rx_sequencer
  import ddr_rx_pkg::*;
#(
  parameter int MAX_WORDS = 16,
  parameter int WCNT_W    = 5
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_sclgen_scl_pos_edge,
  input  logic              i_sclgen_scl_neg_edge,
  input  logic              i_ccc_start,
  input  logic              i_ccc_abort,
  input  logic              i_rx_mode_done,
  input  logic              i_rx_pre,
  input  logic              i_rx_error,
  input  logic              i_rx_error_done,
  output logic              o_rx_en,
  output logic [3:0]        o_rx_mode,
  output logic              o_byte_valid,
  output logic [WCNT_W-1:0] o_word_count,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  localparam logic [WCNT_W-1:0] MAX_CNT = WCNT_W'(MAX_WORDS);

  rx_state_t         r_state;
  logic              r_armed;
  logic              r_pre0;
  logic              r_chk_win;
  logic              r_rx_en;
  logic [3:0]        r_rx_mode;
  logic              r_byte_valid;
  logic [WCNT_W-1:0] r_word_count;
  logic              r_busy;
  logic              r_done;
  logic              r_error;

  rx_state_t         w_next_state;
  logic              w_in_pre;
  logic              w_in_chk;
  logic              w_sample;
  logic              w_err_hit;
  logic              w_armed_nxt;
  logic              w_pre0_nxt;
  logic              w_chk_win_nxt;
  logic [WCNT_W-1:0] w_cnt_nxt;
  logic [WCNT_W-1:0] w_cnt_inc;
  logic              w_byte_valid_nxt;
  logic              w_done_nxt;

  assign w_in_pre  = (r_state == ST_PRE0) || (r_state == ST_PRE1);
  assign w_in_chk  = (r_state == ST_PAR) || (r_state == ST_TOKEN) || (r_state == ST_CRC);
  // A preamble bit is only trusted once SCL has actually toggled since the last sample.
  assign w_sample  = w_in_pre && r_armed && i_rx_mode_done;
  // RX flags check errors one cycle late, so the cycle after a check state still counts.
  assign w_err_hit = i_rx_error && (w_in_chk || r_chk_win);
  assign w_cnt_inc = (r_word_count >= MAX_CNT) ? r_word_count : r_word_count + WCNT_W'(1);

  // Next-state and next-output decode; abort overrides everything at the end.
  always_comb begin
    w_next_state     = r_state;
    w_pre0_nxt       = r_pre0;
    w_cnt_nxt        = r_word_count;
    w_byte_valid_nxt = 1'b0;
    w_done_nxt       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_ccc_start) begin
          w_next_state = ST_PRE0;
          w_cnt_nxt    = '0;
        end
      end
      ST_PRE0: begin
        if (w_err_hit) begin
          w_next_state = ST_ERR;
        end else if (w_sample) begin
          w_pre0_nxt   = i_rx_pre;
          w_next_state = ST_PRE1;
        end
      end
      ST_PRE1: begin
        if (w_sample) begin
          case ({r_pre0, i_rx_pre})
            PRE_DATA: w_next_state = (r_word_count >= MAX_CNT) ? ST_ERR : ST_BYTE0;
            PRE_CRC:  w_next_state = ST_TOKEN;
            default:  w_next_state = ST_ERR;
          endcase
        end
      end
      ST_BYTE0: begin
        if (i_rx_mode_done) begin
          w_byte_valid_nxt = 1'b1;
          w_next_state     = ST_BYTE1;
        end
      end
      ST_BYTE1: begin
        if (i_rx_mode_done) begin
          w_byte_valid_nxt = 1'b1;
          w_next_state     = ST_PAR;
        end
      end
      ST_PAR: begin
        if (w_err_hit) begin
          w_next_state = ST_ERR;
        end else if (i_rx_mode_done) begin
          w_cnt_nxt    = w_cnt_inc;
          w_next_state = ST_PRE0;
        end
      end
      ST_TOKEN: begin
        if (w_err_hit) begin
          w_next_state = ST_ERR;
        end else if (i_rx_mode_done) begin
          w_next_state = ST_CRC;
        end
      end
      ST_CRC: begin
        if (w_err_hit) begin
          w_next_state = ST_ERR;
        end else if (i_rx_mode_done) begin
          w_next_state = ST_FIN;
        end
      end
      ST_FIN: begin
        // Completion is only reported once the late-error window has closed.
        if (w_err_hit) begin
          w_next_state = ST_ERR;
        end else begin
          w_done_nxt   = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (i_rx_error_done) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (i_ccc_abort) begin
      w_next_state     = ST_IDLE;
      w_cnt_nxt        = r_word_count;
      w_byte_valid_nxt = 1'b0;
      w_done_nxt       = 1'b0;
    end
  end

  // SCL-edge arming only lives while the FSM stays in the preamble states.
  always_comb begin
    w_armed_nxt = 1'b0;
    if (w_in_pre && ((w_next_state == ST_PRE0) || (w_next_state == ST_PRE1))) begin
      if (w_sample) begin
        w_armed_nxt = 1'b0;
      end else if (i_sclgen_scl_pos_edge || i_sclgen_scl_neg_edge) begin
        w_armed_nxt = 1'b1;
      end else begin
        w_armed_nxt = r_armed;
      end
    end
  end

  // Opens the one-cycle late-error window when leaving a check state.
  always_comb begin
    w_chk_win_nxt = w_in_chk && (w_next_state != r_state) && !i_ccc_abort;
  end

  // State, internal flags and registered outputs.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_state      <= ST_IDLE;
      r_armed      <= 1'b0;
      r_pre0       <= 1'b0;
      r_chk_win    <= 1'b0;
      r_rx_en      <= 1'b0;
      r_rx_mode    <= RX_PREAMBLE;
      r_byte_valid <= 1'b0;
      r_word_count <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_armed      <= w_armed_nxt;
      r_pre0       <= w_pre0_nxt;
      r_chk_win    <= w_chk_win_nxt;
      r_rx_en      <= state_rx_en(w_next_state);
      r_rx_mode    <= state_to_mode(w_next_state);
      r_byte_valid <= w_byte_valid_nxt;
      r_word_count <= w_cnt_nxt;
      r_busy       <= (w_next_state != ST_IDLE);
      r_done       <= w_done_nxt;
      r_error      <= (w_next_state == ST_ERR) && (r_state != ST_ERR);
    end
  end

  assign o_rx_en      = r_rx_en;
  assign o_rx_mode    = r_rx_mode;
  assign o_byte_valid = r_byte_valid;
  assign o_word_count = r_word_count;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_error      = r_error;

endmodule

// File: tb/tb_ddr_rx_sequencer.sv
// Testbench for ddr_rx_sequencer: directed checks of reset, mode sequencing,
// ignored start, unarmed preamble and async reset, then random transfers
// scored against a transfer-level outcome model.
module tb_ddr_rx_sequencer;
  import ddr_rx_pkg::*;

  localparam int MAXW = 16;
  localparam int WW   = 5;

  logic          clk;
  logic          rst_n;
  logic          start, abort, scl_p, scl_n, mdone, pre, rxerr, errdone;
  logic          rx_en, byte_valid, busy, done_o, error_o;
  logic [3:0]    rx_mode;
  logic [WW-1:0] word_count;

  int n_total = 0;
  int n_bad   = 0;
  int cnt_bv  = 0;
  int cnt_dn  = 0;
  int cnt_er  = 0;

  ddr_rx_sequencer #(.MAX_WORDS(MAXW), .WCNT_W(WW)) dut (
    .i_sys_clk             (clk),
    .i_sys_rst             (rst_n),
    .i_sclgen_scl_pos_edge (scl_p),
    .i_sclgen_scl_neg_edge (scl_n),
    .i_ccc_start           (start),
    .i_ccc_abort           (abort),
    .i_rx_mode_done        (mdone),
    .i_rx_pre              (pre),
    .i_rx_error            (rxerr),
    .i_rx_error_done       (errdone),
    .o_rx_en               (rx_en),
    .o_rx_mode             (rx_mode),
    .o_byte_valid          (byte_valid),
    .o_word_count          (word_count),
    .o_busy                (busy),
    .o_done                (done_o),
    .o_error               (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid) cnt_bv++;
      if (done_o)     cnt_dn++;
      if (error_o)    cnt_er++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    start   = 1'b0;
    scl_p   = 1'b0;
    scl_n   = 1'b0;
    mdone   = 1'b0;
    rxerr   = 1'b0;
    errdone = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic preamble(input logic b0, input logic b1);
    scl_p = 1'b1;
    tick();
    idle($urandom_range(0, 1));
    mdone = 1'b1;
    pre   = b0;
    tick();
    scl_n = 1'b1;
    tick();
    idle($urandom_range(0, 1));
    mdone = 1'b1;
    pre   = b1;
    tick();
  endtask

  task automatic rx_done();
    idle($urandom_range(0, 2));
    mdone = 1'b1;
    tick();
  endtask

  // Outcome of one transfer from its shape: n words requested, fault kind at word k.
  // kinds: 0 clean, 1 error in PAR, 2 error right after PAR, 3 bad preamble,
  //        4 error in TOKEN, 5 error in CRC, 6 error right after CRC, 7 abort in BYTE1
  function automatic void model(input int n, input int kind, input int k,
                                output int bv, output int wc, output int dn, output int er);
    dn = 0;
    er = 1;
    if (kind == 1) begin
      bv = 2 * (k + 1); wc = k;
    end else if (kind == 2) begin
      bv = 2 * (k + 1); wc = k + 1;
    end else if (kind == 3) begin
      bv = 2 * k; wc = k;
    end else if (kind == 7) begin
      bv = 2 * k + 1; wc = k; er = 0;
    end else if (n > MAXW) begin
      bv = 2 * MAXW; wc = MAXW;
    end else if (kind >= 4) begin
      bv = 2 * n; wc = n;
    end else begin
      bv = 2 * n; wc = n; dn = 1; er = 0;
    end
  endfunction

  task automatic enter_err_and_recover();
    check("err_mode", rx_mode, RX_ERROR);
    check("err_busy", busy, 1);
    idle($urandom_range(0, 2));
    errdone = 1'b1;
    tick();
    check("err_exit_busy", busy, 0);
  endtask

  task automatic run_txn(input int n, input int kind, input int k);
    start = 1'b1;
    tick();
    for (int w = 0; w < n; w++) begin
      if (kind == 3 && w == k) begin
        preamble(1'($urandom_range(0, 1)), 1'b0);
        enter_err_and_recover();
        return;
      end
      preamble(1'b1, 1'b1);
      if (w >= MAXW) begin
        enter_err_and_recover();
        return;
      end
      rx_done();
      if (kind == 7 && w == k) begin
        abort = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_rx_en", rx_en, 0);
        abort = 1'b0;
        return;
      end
      rx_done();
      if (kind == 1 && w == k) begin
        idle($urandom_range(0, 1));
        rxerr = 1'b1;
        mdone = 1'b1;
        tick();
        enter_err_and_recover();
        return;
      end
      rx_done();
      if (kind == 2 && w == k) begin
        rxerr = 1'b1;
        tick();
        enter_err_and_recover();
        return;
      end
    end
    preamble(1'b0, 1'b1);
    if (kind == 4) begin
      rxerr = 1'b1;
      mdone = 1'b1;
      tick();
      enter_err_and_recover();
      return;
    end
    rx_done();
    if (kind == 5) begin
      rxerr = 1'b1;
      mdone = 1'b1;
      tick();
      enter_err_and_recover();
      return;
    end
    mdone = 1'b1;
    tick();
    if (kind == 6) begin
      rxerr = 1'b1;
      tick();
      enter_err_and_recover();
      return;
    end
  endtask

  initial begin
    int n, kind, k, t;
    int e_bv, e_wc, e_dn, e_er;
    int b_bv, b_dn, b_er;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; scl_p = 1'b0; scl_n = 1'b0;
    mdone = 1'b0; pre = 1'b0; rxerr = 1'b0; errdone = 1'b0;
    #12;
    check("rst_rx_en", rx_en, 0);
    check("rst_mode", rx_mode, RX_PREAMBLE);
    check("rst_bv", byte_valid, 0);
    check("rst_wc", word_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done_o, 0);
    check("rst_error", error_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // directed walk through one data word
    start = 1'b1;
    tick();
    check("start_busy", busy, 1);
    check("start_rx_en", rx_en, 1);
    check("start_mode", rx_mode, RX_PREAMBLE);
    mdone = 1'b1;
    pre   = 1'b0;
    tick();
    check("unarmed_stay", rx_mode, RX_PREAMBLE);
    preamble(1'b1, 1'b1);
    check("data_mode", rx_mode, RX_DESER_BYTE);
    mdone = 1'b1;
    tick();
    check("byte0_valid", byte_valid, 1);
    mdone = 1'b1;
    tick();
    check("par_mode", rx_mode, RX_CHK_PAR);
    start = 1'b1;
    tick();
    check("start_ignored_mode", rx_mode, RX_CHK_PAR);
    mdone = 1'b1;
    tick();
    check("wc_one", word_count, 1);
    start = 1'b1;
    tick();
    check("start_ignored_wc", word_count, 1);
    preamble(1'b0, 1'b1);
    check("token_mode", rx_mode, RX_CHK_TOKEN);
    mdone = 1'b1;
    tick();
    check("crc_mode", rx_mode, RX_CHK_CRC);
    rst_n = 1'b0;
    #1;
    check("midrst_rx_en", rx_en, 0);
    check("midrst_mode", rx_mode, RX_PREAMBLE);
    check("midrst_wc", word_count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done_o, 0);
    check("midrst_error", error_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // random transfers against the outcome model
    for (int i = 0; i < 40; i++) begin
      k = 0;
      if (i == 0) begin
        n = 1; kind = 0;
      end else if (i == 1) begin
        n = 16; kind = 0;
      end else if (i == 2) begin
        n = 17; kind = 0;
      end else if (i == 3) begin
        n = 3; kind = 2; k = 1;
      end else if (i == 4) begin
        n = 2; kind = 7; k = 1;
      end else begin
        n = $urandom_range(0, 17);
        if (n == 0) begin
          t = $urandom_range(0, 3);
          kind = (t == 0) ? 0 : t + 3;
        end else if (n == 17) begin
          t = $urandom_range(0, 4);
          kind = (t == 4) ? 7 : t;
          k = $urandom_range(0, 15);
        end else begin
          kind = $urandom_range(0, 7);
          k = $urandom_range(0, n - 1);
        end
      end
      model(n, kind, k, e_bv, e_wc, e_dn, e_er);
      b_bv = cnt_bv;
      b_dn = cnt_dn;
      b_er = cnt_er;
      run_txn(n, kind, k);
      idle(2);
      check("txn_bv", cnt_bv - b_bv, e_bv);
      check("txn_wc", word_count, e_wc);
      check("txn_done", cnt_dn - b_dn, e_dn);
      check("txn_error", cnt_er - b_er, e_er);
      check("txn_idle_busy", busy, 0);
      check("txn_idle_rx_en", rx_en, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
